// File: rtl/alu_multicycle.sv
// alu_multicycle: execute-stage ALU with single-cycle logic/arithmetic ops and
// iterative unsigned multiply/divide behind a start/busy/done handshake.
// All outputs are registered; busy stalls the pipeline while MULU/DIVU iterate.
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             illegal_op
);

    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_NOR  = 4'b0100,
        OP_SLTU = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_MULU = 4'b1000,
        OP_DIVU = 4'b1001
    } op_t;

    // Architectural state
    state_t           state, state_n;
    logic             busy_n, done_n;
    logic [WIDTH-1:0] res_lo_n, res_hi_n;
    logic             zero_n, ovf_n, dbz_n, ill_n;

    // Iteration state: work_hi is the accumulator (MUL) or partial remainder (DIV);
    // work_lo holds the multiplier being shifted out (MUL) or the dividend being
    // shifted out while quotient bits shift in (DIV); operand is the latched
    // multiplicand or divisor.
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] work_hi, work_hi_n;
    logic [WIDTH-1:0] work_lo, work_lo_n;
    logic [WIDTH-1:0] operand, operand_n;

    // Single-cycle datapath
    logic [WIDTH-1:0] sum, diff;
    logic [WIDTH-1:0] sc_lo;
    logic             sc_ovf, sc_ill;

    // Iteration datapath
    logic [WIDTH-1:0] mul_addend;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;
    logic [WIDTH:0]   rem_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem, div_quo;

    assign sum  = a + b;
    assign diff = a - b;

    // Result and flags of the single-cycle operations, decoded from op
    always_comb begin
        sc_lo  = '0;
        sc_ovf = 1'b0;
        sc_ill = 1'b0;
        case (op)
            OP_AND:  sc_lo = a & b;
            OP_OR:   sc_lo = a | b;
            OP_ADD: begin
                sc_lo  = sum;
                sc_ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_XOR:  sc_lo = a ^ b;
            OP_NOR:  sc_lo = ~(a | b);
            OP_SLTU: sc_lo = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SUB: begin
                sc_lo  = diff;
                sc_ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            OP_SLT:  sc_lo = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_MULU, OP_DIVU: sc_lo = '0;
            default: sc_ill = 1'b1;
        endcase
    end

    // One shift-add multiply step: {work_hi, work_lo} is the running 2*WIDTH product
    // register; the carry out of the add becomes the new top bit as it shifts right.
    always_comb begin
        mul_addend = work_lo[0] ? operand : '0;
        mul_sum    = {1'b0, work_hi} + {1'b0, mul_addend};
        mul_hi     = mul_sum[WIDTH:1];
        mul_lo     = {mul_sum[0], work_lo[WIDTH-1:1]};
    end

    // One restoring-divide step: bring in the next dividend bit, subtract the
    // divisor if it fits, and shift the resulting quotient bit into work_lo.
    always_comb begin
        rem_shift = {work_hi, work_lo[MSB]};
        div_ge    = (rem_shift >= {1'b0, operand});
        div_rem   = div_ge ? (rem_shift[MSB:0] - operand) : rem_shift[MSB:0];
        div_quo   = {work_lo[MSB-1:0], div_ge};
    end

    // FSM next-state and registered-output next values
    always_comb begin
        state_n   = state;
        busy_n    = busy;
        done_n    = 1'b0;
        res_lo_n  = result_lo;
        res_hi_n  = result_hi;
        zero_n    = zero;
        ovf_n     = overflow;
        dbz_n     = div_by_zero;
        ill_n     = illegal_op;
        cnt_n     = cnt;
        work_hi_n = work_hi;
        work_lo_n = work_lo;
        operand_n = operand;

        case (state)
            IDLE: begin
                if (start) begin
                    if (op == OP_MULU) begin
                        operand_n = a;
                        work_lo_n = b;
                        work_hi_n = '0;
                        cnt_n     = CNT_W'(WIDTH);
                        busy_n    = 1'b1;
                        state_n   = MUL;
                    end else if ((op == OP_DIVU) && (b != '0)) begin
                        operand_n = b;
                        work_lo_n = a;
                        work_hi_n = '0;
                        cnt_n     = CNT_W'(WIDTH);
                        busy_n    = 1'b1;
                        state_n   = DIV;
                    end else if (op == OP_DIVU) begin
                        // Divide by zero: all-ones quotient, dividend as remainder
                        done_n   = 1'b1;
                        res_lo_n = '1;
                        res_hi_n = a;
                        zero_n   = 1'b0;
                        ovf_n    = 1'b0;
                        dbz_n    = 1'b1;
                        ill_n    = 1'b0;
                    end else begin
                        done_n   = 1'b1;
                        res_lo_n = sc_lo;
                        res_hi_n = '0;
                        zero_n   = (sc_lo == '0);
                        ovf_n    = sc_ovf;
                        dbz_n    = 1'b0;
                        ill_n    = sc_ill;
                    end
                end
            end

            MUL: begin
                work_hi_n = mul_hi;
                work_lo_n = mul_lo;
                cnt_n     = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    done_n   = 1'b1;
                    busy_n   = 1'b0;
                    res_hi_n = mul_hi;
                    res_lo_n = mul_lo;
                    zero_n   = (mul_lo == '0);
                    ovf_n    = 1'b0;
                    dbz_n    = 1'b0;
                    ill_n    = 1'b0;
                    state_n  = IDLE;
                end
            end

            DIV: begin
                work_hi_n = div_rem;
                work_lo_n = div_quo;
                cnt_n     = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    done_n   = 1'b1;
                    busy_n   = 1'b0;
                    res_hi_n = div_rem;
                    res_lo_n = div_quo;
                    zero_n   = (div_quo == '0);
                    ovf_n    = 1'b0;
                    dbz_n    = 1'b0;
                    ill_n    = 1'b0;
                    state_n  = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any operation without a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            result_lo   <= '0;
            result_hi   <= '0;
            zero        <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
            cnt         <= '0;
            work_hi     <= '0;
            work_lo     <= '0;
            operand     <= '0;
        end else begin
            state       <= state_n;
            busy        <= busy_n;
            done        <= done_n;
            result_lo   <= res_lo_n;
            result_hi   <= res_hi_n;
            zero        <= zero_n;
            overflow    <= ovf_n;
            div_by_zero <= dbz_n;
            illegal_op  <= ill_n;
            cnt         <= cnt_n;
            work_hi     <= work_hi_n;
            work_lo     <= work_lo_n;
            operand     <= operand_n;
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Testbench for alu_multicycle: table of vectors with constant expectations,
// pushed to a scoreboard on issue and checked when done pulses, plus
// hand-written sequences for start-while-busy, back-to-back and mid-op reset.
`timescale 1ns/1ps
module tb_alu_multicycle;

    localparam int W = 32;

    localparam logic [3:0] AND_ = 4'b0000;
    localparam logic [3:0] OR_  = 4'b0001;
    localparam logic [3:0] ADD  = 4'b0010;
    localparam logic [3:0] XOR_ = 4'b0011;
    localparam logic [3:0] NOR_ = 4'b0100;
    localparam logic [3:0] SLTU = 4'b0101;
    localparam logic [3:0] SUB  = 4'b0110;
    localparam logic [3:0] SLT  = 4'b0111;
    localparam logic [3:0] MULU = 4'b1000;
    localparam logic [3:0] DIVU = 4'b1001;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, zero, overflow, div_by_zero, illegal_op;
    logic [W-1:0] result_lo, result_hi;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
        .zero(zero), .overflow(overflow), .div_by_zero(div_by_zero),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a, b, lo, hi;
        logic         z, ov, dz, il;
        int           lat;
    } vec_t;

    typedef struct {
        vec_t v;
        int   acc;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   passed = 0;
    int   total = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic [W-1:0] lo, input logic [W-1:0] hi,
                                input logic z, input logic ov, input logic dz, input logic il,
                                input int lat);
        vec_t v;
        v.op = o; v.a = x; v.b = y; v.lo = lo; v.hi = hi;
        v.z = z; v.ov = ov; v.dz = dz; v.il = il; v.lat = lat;
        return v;
    endfunction

    // Called at a negedge: present one start request; optionally expect a done for it
    task automatic drive(input vec_t v, input bit track);
        exp_t e;
        start = 1'b1; op = v.op; a = v.a; b = v.b;
        if (track) begin
            e.v = v;
            e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            chk(name, W'(sb.size()), '0);
            sb.delete();
        end
    endtask

    // Scoreboard monitor: every done must match the oldest outstanding request
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", W'(done), '0);
            end else begin
                e = sb.pop_front();
                chk("result_lo", result_lo, e.v.lo);
                chk("result_hi", result_hi, e.v.hi);
                chk("zero", W'(zero), W'(e.v.z));
                chk("overflow", W'(overflow), W'(e.v.ov));
                chk("div_by_zero", W'(div_by_zero), W'(e.v.dz));
                chk("illegal_op", W'(illegal_op), W'(e.v.il));
                chk("busy_at_done", W'(busy), '0);
                chk("latency", W'(cyc - e.acc), W'(e.v.lat));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        vec_t v;

        //                 op    a             b             lo            hi            z     ov    dz    il    lat
        vecs.push_back(mk(ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 0));
        vecs.push_back(mk(SUB,  32'h12345678, 32'h12345678, 32'h00000000, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 0));
        vecs.push_back(mk(SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 0));
        vecs.push_back(mk(SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 0));
        vecs.push_back(mk(4'b1100, 32'h1,     32'h2,        32'h00000000, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 0));
        vecs.push_back(mk(AND_, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 0));
        vecs.push_back(mk(OR_,  32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 0));
        vecs.push_back(mk(XOR_, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 0));
        vecs.push_back(mk(NOR_, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 0));
        vecs.push_back(mk(NOR_, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 0));
        vecs.push_back(mk(SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 0));
        vecs.push_back(mk(ADD,  32'h80000000, 32'h80000000, 32'h00000000, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 0));
        vecs.push_back(mk(SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 0));
        vecs.push_back(mk(SLT,  32'h80000000, 32'h7FFFFFFF, 32'h00000001, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 0));
        vecs.push_back(mk(MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0, W));
        vecs.push_back(mk(MULU, 32'h12345678, 32'h00000010, 32'h23456780, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, W));
        vecs.push_back(mk(MULU, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, W));
        vecs.push_back(mk(DIVU, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0, 1'b0, 1'b0, W));
        vecs.push_back(mk(DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b0, 1'b0, 1'b1, 1'b0, 0));
        vecs.push_back(mk(DIVU, 32'd7,        32'd100,      32'd0,        32'd7,        1'b1, 1'b0, 1'b0, 1'b0, W));
        vecs.push_back(mk(DIVU, 32'h80000000, 32'd3,        32'h2AAAAAAA, 32'd2,        1'b0, 1'b0, 1'b0, 1'b0, W));
        vecs.push_back(mk(DIVU, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 1'b0, 1'b0, 1'b0, W));
        vecs.push_back(mk(4'b1111, 32'h5,     32'h5,        32'h00000000, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 0));
        vecs.push_back(mk(ADD,  32'd2,        32'd3,        32'd5,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 0));

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        chk("rst_result_lo", result_lo, '0);
        chk("rst_result_hi", result_hi, '0);
        chk("rst_zero", W'(zero), '0);
        chk("rst_overflow", W'(overflow), '0);
        chk("rst_div_by_zero", W'(div_by_zero), '0);
        chk("rst_illegal_op", W'(illegal_op), '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Vector table
        foreach (vecs[i]) begin
            drive(vecs[i], 1'b1);
            if (vecs[i].lat > 0) chk("busy_after_accept", W'(busy), W'(1));
            wait_idle(W + 10, "done_timeout");
            @(negedge clk);
            chk("done_one_cycle", W'(done), '0);
            chk("result_hold", result_lo, vecs[i].lo);
        end

        // Start while busy is ignored; a start in the done cycle is accepted
        drive(mk(MULU, 32'd3, 32'd4, 32'd12, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, W), 1'b1);
        repeat (4) @(negedge clk);
        drive(mk(ADD, 32'd1, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0), 1'b0);
        chk("busy_ignores_start", W'(busy), W'(1));
        for (int i = 0; i < W + 10; i++) begin
            if (done) break;
            @(negedge clk);
        end
        chk("mul_done_seen", W'(done), W'(1));
        drive(mk(ADD, 32'd2, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0), 1'b1);
        wait_idle(W + 10, "b2b_timeout");
        @(negedge clk);

        // Asynchronous reset in the middle of a divide
        drive(mk(DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0, W), 1'b0);
        repeat (9) @(negedge clk);
        chk("busy_mid_div", W'(busy), W'(1));
        chk("prev_result_before_rst", result_lo, 32'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", W'(busy), '0);
        chk("abort_done", W'(done), '0);
        chk("abort_result_lo", result_lo, '0);
        chk("abort_result_hi", result_hi, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 5) @(negedge clk);
        chk("idle_after_abort", W'(busy), '0);
        drive(mk(ADD, 32'd2, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0), 1'b1);
        wait_idle(W + 10, "post_reset_timeout");
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
Parametrised-width ALU that succeeds the single-cycle execute-stage ALU. It adds signed overflow detection, XOR, unsigned set-less-than, and iterative unsigned multiply and divide. It uses a start/busy/done handshake with registered outputs, so the pipeline stalls the EX stage while busy is high. Single-cycle ops complete in 1 clock; MULU and DIVU take WIDTH iterations.

Parameters:
WIDTH, 32, operand and result width in bits; must be ≥ 4.
CNT_W, $clog2(WIDTH)+1, width of the internal iteration counter.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only when busy=0.
op  input  4  operation code, sampled with start.
a  input  WIDTH  operand A, sampled with start.
b  input  WIDTH  operand B, sampled with start.
busy  output  1  high from the cycle after start is accepted until the cycle done is asserted.
done  output  1  one-cycle pulse; the result outputs are valid from this cycle.
result_lo  output  WIDTH  primary result; product low half for MULU; quotient for DIVU.
result_hi  output  WIDTH  product high half for MULU; remainder for DIVU; 0 for all other ops.
zero  output  1  result_lo == 0.
overflow  output  1  signed overflow; ADD and SUB only, 0 otherwise.
div_by_zero  output  1  DIVU with b == 0.
illegal_op  output  1  op is not in the encoding list below.

Behaviour:
- Op encoding:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0011 XOR
  - 0100 NOR
  - 0101 SLTU
  - 0110 SUB
  - 0111 SLT (signed)
  - 1000 MULU
  - 1001 DIVU
  - 1010–1111 illegal.
- Reset: state=IDLE. busy, done, result_lo, result_hi, zero, overflow, div_by_zero and illegal_op are all 0. Counter and working registers are 0.
- FSM states: IDLE, MUL, DIV.
  - IDLE + start with a single-cycle op or an illegal op: compute the result and register all outputs at the next edge, with done=1. Stay in IDLE. Latency is 1 cycle and busy never rises.
  - IDLE + start with MULU, b≠0 divisor irrelevant: latch a and b, clear the accumulator, set busy=1, counter=WIDTH, go to MUL.
  - IDLE + start with DIVU, b≠0: latch a and b, clear the remainder, busy=1, counter=WIDTH, go to DIV.
  - IDLE + start with DIVU, b==0: no iteration. Next edge gives done=1, div_by_zero=1, result_lo=all ones, result_hi=a. Stay in IDLE.
  - MUL: shift-add, one multiplier bit per cycle, LSB first, producing a 2·WIDTH-bit unsigned product. The counter decrements each cycle. The edge on which the counter reaches 0 writes {result_hi, result_lo}, sets done=1 and busy=0, and returns to IDLE.
  - DIV: restoring division, one quotient bit per cycle, MSB first. The completion rule is the same as MUL.
  - MULU/DIVU latency: done is asserted WIDTH cycles after the acceptance edge. The next start can be accepted in the cycle done=1, giving back-to-back throughput.
- start while busy=1 is ignored. Operands and the in-flight result are unaffected.
- Result outputs and flags hold their values until the next done. done stays high for exactly one cycle.
- ADD/SUB wrap modulo 2^WIDTH.
  - ADD overflow = (a[MSB]==b[MSB]) && (sum[MSB]≠a[MSB]).
  - SUB overflow = (a[MSB]≠b[MSB]) && (diff[MSB]≠a[MSB]).
- SLT/SLTU: result_lo = 1 or 0, zero-extended.
- Illegal op: result_lo=0, result_hi=0, illegal_op=1, zero=1, done=1.
- Flag updates on each done:
  - zero is recomputed from the new result_lo.
  - Flags not applicable to the completing op are cleared.
- rst_n asserted mid-operation aborts immediately to IDLE with all outputs 0; no done is produced.

Test Plan:
- ADD a=0x7FFFFFFF, b=0x00000001 (WIDTH=32) -> one cycle later: done=1, result_lo=0x80000000, overflow=1, zero=0, busy stays 0.
- SUB a=b=0x12345678, then SLT a=0xFFFFFFFF, b=1, then SLTU with the same operands -> result_lo 0 with zero=1, then 1, then 0. Op 1100 -> illegal_op=1, result_lo=0.
- MULU a=b=0xFFFFFFFF -> busy high for 32 cycles, done exactly 32 cycles after acceptance, result_hi=0xFFFFFFFE, result_lo=0x00000001.
- DIVU a=100, b=7 -> result_lo=14, result_hi=2 at done (32 cycles). DIVU a=5, b=0 -> done after 1 cycle, div_by_zero=1, result_lo=0xFFFFFFFF, result_hi=5.
- Start an ADD 5 cycles into a MULU (3×4) -> ADD ignored, MULU completes with result_lo=12. A new start in the done cycle is accepted.
- Drive rst_n=0 10 cycles into a DIVU -> busy=0 and outputs 0 asynchronously. After release, no done pulse occurs, and a fresh ADD 2+3 returns 5.
